// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner arbitration for the board LED bank.
// Requesters hold req_i high to ask for the bank. The owner's grant lasts at
// most SLICE_CYCLES cycles while someone else is waiting. A one-cycle blank
// gap separates consecutive owners.
// Optional feature macro: LED_ARB_HEARTBEAT_EN. When it is defined, a
// heartbeat blinks on leds[0] while no requester owns the bank.
module led_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LED_W        = 7,
  parameter int SLICE_CYCLES = 25000,
  parameter int HB_DIV       = 25000
) (
  input  logic                     clk_50MHz,
  input  logic                     arst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LED_W-1:0] pattern_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  output logic [LED_W-1:0]         leds,
  output logic                     hb_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SL_W  = $clog2(SLICE_CYCLES);
  localparam logic [SL_W-1:0]  SLICE_LAST = SL_W'(SLICE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [SL_W-1:0]      slice_q, slice_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic [LED_W-1:0]     leds_q, leds_d;

  logic [PTR_W-1:0]     win;
  logic                 win_vld;
  logic [PTR_W:0]       scan_idx;
  logic [NUM_REQ-1:0]   own_mask;
  logic                 others_waiting;
  logic                 release_now;
  logic [LED_W-1:0]     idle_leds;

  // Wrapping increment of a requester index.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] k);
    if (k == PTR_LAST) begin
      return '0;
    end
    return k + PTR_W'(1);
  endfunction

`ifdef LED_ARB_HEARTBEAT_EN
  localparam int HB_W = $clog2(HB_DIV);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);

  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;

  // Free-running heartbeat divider; toggles the level on every wrap.
  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  // Heartbeat registers; these run in every arbitration state.
  always_ff @(posedge clk_50MHz or posedge arst) begin
    if (arst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign hb_o = hb_q;
  // Use the next heartbeat level, so that the registered leds[0] matches hb_o.
  assign idle_leds = LED_W'(hb_d);
`else
  assign hb_o      = 1'b0;
  assign idle_leds = '0;
`endif

  // Round-robin search: first requesting index at or above rr_ptr, with wrap.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!win_vld && req_i[scan_idx[PTR_W-1:0]]) begin
        win     = scan_idx[PTR_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Release detection for the current owner. The owner releases on its own
  // drop, or when its slice has expired while another requester is waiting.
  always_comb begin
    own_mask       = NUM_REQ'(1) << owner_q;
    others_waiting = |(req_i & ~own_mask);
    release_now    = !req_i[owner_q] || ((slice_q == SLICE_LAST) && others_waiting);
  end

  // Next-state logic, with next values for the registered outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    slice_d  = slice_q;
    gnt_d    = '0;
    busy_d   = 1'b0;
    leds_d   = idle_leds;

    case (state_q)
      S_IDLE, S_GAP: begin
        if (win_vld) begin
          state_d  = S_GRANT;
          owner_d  = win;
          rr_ptr_d = next_ptr(win);
          slice_d  = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d = S_GAP;
        end else if (slice_q != SLICE_LAST) begin
          // A sole requester saturates here and keeps the bank.
          slice_d = slice_q + SL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_GRANT: begin
        gnt_d  = NUM_REQ'(1) << owner_d;
        busy_d = 1'b1;
        leds_d = pattern_i[owner_d*LED_W +: LED_W];
      end
      S_GAP:   leds_d = '0;
      default: leds_d = idle_leds;
    endcase
  end

  // State and output registers. A reset clears them immediately, even mid-grant.
  always_ff @(posedge clk_50MHz or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      slice_q  <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      slice_q  <= slice_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      leds_q   <= leds_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;
  assign leds   = leds_q;

endmodule
